// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the shift-add multiplier (seq_mult_ctrl and seq_mult_dp).
// Signed operation is enabled by defining SEQ_MULT_SIGNED_EN.
package seq_mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Start-accept to valid distance in cycles.
  function automatic int latency(input int w);
    return 2 * w + 2;
  endfunction

  localparam int LATENCY = latency(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_mult_dp.sv
// Accumulator datapath: multiplicand register, {carry, acc_hi, acc_lo} and the add/shift step.
// SEQ_MULT_SIGNED_EN adds two's-complement operation (sign-extended add, final-step subtract).
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_init,
  input  logic               i_add,
  input  logic               i_shift,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               i_last,
  input  logic               i_signed,
`endif
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_shiftNext
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_accHi;
  logic [WIDTH-1:0] r_accLo;
  logic             r_carry;
`ifdef SEQ_MULT_SIGNED_EN
  logic             r_signed;
`endif

  logic [WIDTH:0]   w_hiExt;
  logic [WIDTH:0]   w_mExt;
  logic [WIDTH:0]   w_sum;

  // The sum keeps its top bit in carry, which also supplies the sign for the arithmetic shift.
  always_comb begin
    w_hiExt = {1'b0, r_accHi};
    w_mExt  = {1'b0, r_mcand};
`ifdef SEQ_MULT_SIGNED_EN
    if (r_signed) begin
      w_hiExt = {r_accHi[WIDTH-1], r_accHi};
      w_mExt  = {r_mcand[WIDTH-1], r_mcand};
    end
`endif
    w_sum = w_hiExt;
    if (r_accLo[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
      if (r_signed && i_last) w_sum = w_hiExt - w_mExt;
      else                    w_sum = w_hiExt + w_mExt;
`else
      w_sum = w_hiExt + w_mExt;
`endif
    end
  end

  assign o_shiftNext = {r_carry, r_accHi, r_accLo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_accHi  <= '0;
      r_accLo  <= '0;
      r_carry  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_accLo  <= i_b;
`ifdef SEQ_MULT_SIGNED_EN
      r_signed <= i_signed;
`endif
    end else if (i_init) begin
      r_accHi <= '0;
      r_carry <= 1'b0;
    end else if (i_add) begin
      {r_carry, r_accHi} <= w_sum;
    end else if (i_shift) begin
      {r_accHi, r_accLo} <= o_shiftNext;
      r_carry            <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Multi-cycle shift-add multiplier: control FSM, iteration counter and held product register.
// Define SEQ_MULT_SIGNED_EN to add the signed_op input for two's-complement operands.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rstFSM,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_load;
  logic               w_last;
  logic [2*WIDTH-1:0] w_shiftNext;

  assign w_load = (r_state == IDLE) && start;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .i_rst       (rstFSM),
    .i_load      (w_load),
    .i_init      (r_state == INIT),
    .i_add       (r_state == ADD),
    .i_shift     (r_state == SHIFT),
`ifdef SEQ_MULT_SIGNED_EN
    .i_last      (w_last),
    .i_signed    (signed_op),
`endif
    .i_a         (a),
    .i_b         (b),
    .o_shiftNext (w_shiftNext)
  );

  // Product is captured from the final shift result so it is readable in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rstFSM) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      product <= '0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= INIT;
            busy    <= 1'b1;
          end
        end
        INIT: begin
          r_cnt   <= '0;
          r_state <= ADD;
        end
        ADD: r_state <= SHIFT;
        SHIFT: begin
          if (w_last) begin
            r_state <= DONE;
            valid   <= 1'b1;
            product <= w_shiftNext;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ADD;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Parametrised multi-cycle shift-add multiplier: control FSM, iteration counter and accumulator datapath in one block.
- Successor to the fixed 4-state add/shift controller. The iteration counter is internal, so no external done input is needed.
- Adds a start/busy/valid handshake, a held product register and a WIDTH generic.
- Sits between operand registers and the ALU result mux; it is the long-latency multiply path.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rstFSM  in  1  synchronous active-high reset.
start  in  1  request; sampled only in IDLE.
a  in  WIDTH  multiplicand; captured when start is accepted.
b  in  WIDTH  multiplier; captured when start is accepted.
busy  out  1  high in INIT, ADD, SHIFT and DONE.
valid  out  1  one-cycle pulse in DONE; product is valid from then on.
product  out  2*WIDTH  result; held until the next accepted start.

Behaviour:
Reset:
- rstFSM high at a clock edge -> state=IDLE, busy=0, valid=0, product=0, counter=0, accumulator=0.
- Reset takes priority over every other event, including reset mid-operation; the operation in flight is lost.

States and transitions (registered):
- IDLE: busy=0. start=1 -> capture a into mcand_q and b into acc_lo -> INIT. start=0 -> stay in IDLE.
- INIT: acc_hi=0, carry=0, cnt=0 -> ADD. The start input is ignored.
- ADD: if acc_lo[0]=1 then {carry,acc_hi} = acc_hi + mcand_q, a (WIDTH+1)-bit sum; otherwise no change -> SHIFT.
- SHIFT: {carry,acc_hi,acc_lo} logically shifted right by 1, carry cleared.
  - cnt==WIDTH-1 -> DONE.
  - Otherwise cnt++ -> ADD.
- DONE: product <= {acc_hi,acc_lo}, valid=1 for this cycle only -> IDLE.

Latency and handshake:
- Start accepted at edge N -> valid high in the cycle after edge N+2*WIDTH+1, i.e. 2*WIDTH+2 cycles after acceptance (18 for WIDTH=8).
- Latency is fixed and independent of the operand values.
- start while busy=1 is ignored and not queued.
- start held high in the DONE cycle is not accepted. It is accepted on the next cycle, in IDLE, so back-to-back issue costs one idle cycle.
- product changes only on the DONE edge. It does not change at start acceptance, so the previous result stays readable during the next operation.

Arithmetic:
- No overflow is possible: the product of two WIDTH-bit operands fits in 2*WIDTH bits.
- The carry bit captures the adder overflow before each shift.
- Operand of 0 -> full latency still applies, result 0.

Optional Feature:
Macro: SEQ_MULT_SIGNED_EN
- Defined: adds input port signed_op (1 bit, captured with a/b).
  - When signed_op=1, operands are two's complement.
  - ADD uses sign-extended mcand_q.
  - SHIFT is arithmetic, with the sign taken from the WIDTH+1 sum.
  - On the final iteration (cnt==WIDTH-1), ADD subtracts mcand_q instead of adding it when acc_lo[0]=1.
  - Latency is unchanged.
  - When signed_op=0, behaviour is identical to the unsigned path.
- Undefined: the signed_op port is absent and only the unsigned path exists.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum (IDLE, INIT, ADD, SHIFT, DONE), 3-bit encoding;
  - localparam function for CNT_W;
  - LATENCY constant = 2*WIDTH+2, for the bench.
- Sub-module seq_mult_dp: accumulator, carry, mcand_q and add/shift datapath. It is driven by load/add/shift strobes from the FSM in seq_mult_ctrl.

Test Plan:
- WIDTH=8, a=13, b=11, start pulsed 1 cycle -> valid exactly 18 cycles later with product=16'd143; busy high for 18 cycles.
- WIDTH=8, a=255, b=255 -> product=16'hFE01. a=0, b=200 -> product=0 with the same 18-cycle latency.
- start re-pulsed while busy with a=2, b=2 -> ignored; the first result is returned; no second valid until a new start in IDLE.
- rstFSM asserted in the 5th ADD/SHIFT pair -> next cycle busy=0, valid=0, product=0. Then a=7, b=6 -> product=42.
- start held high continuously, operand pairs (3,4),(5,6) -> results 12 then 30; valid pulses 19 cycles apart; product holds 12 until the second DONE.
- SEQ_MULT_SIGNED_EN defined, WIDTH=8:
  - signed_op=1, a=-3, b=5 -> 16'hFFF1.
  - signed_op=1, a=-128, b=-128 -> 16'h4000.
  - signed_op=0, a=8'hFD, b=5 -> 16'd1265.
